// File: rtl/tiadc_pkg.sv
// Shared TIADC capture-path types and default sizing, also used by the AXI read master.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tiadc_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } rresp_t;

   localparam int TIADC_DATA_WIDTH = 16;
   localparam int TIADC_BURST_LEN  = 256;
   localparam int TIADC_NUM_CH     = 4;

endpackage

// File: rtl/tiadc_sample_deinterleaver.sv
// Regroups NUM_CH consecutive R-channel sample beats into one lane-per-ADC word; checks RLAST framing and RRESP.
// Latency: word is valid on the edge after its closing beat is accepted; one beat per cycle sustained.
// Backpressure: only a closing beat is held off (S_RREADY low) while an unaccepted word occupies the output.
module tiadc_sample_deinterleaver
   import tiadc_pkg::*;
#(
   parameter int DATA_WIDTH = TIADC_DATA_WIDTH,
   parameter int NUM_CH     = TIADC_NUM_CH,
   parameter int BURST_LEN  = TIADC_BURST_LEN
) (
   input  logic                         M_AXI_ACLK,
   input  logic                         M_AXI_ARESETN,
   input  logic [DATA_WIDTH-1:0]        S_RDATA,
   input  logic [1:0]                   S_RRESP,
   input  logic                         S_RLAST,
   input  logic                         S_RVALID,
   output logic                         S_RREADY,
   output logic [NUM_CH*DATA_WIDTH-1:0] M_TDATA,
   output logic [NUM_CH-1:0]            M_TKEEP,
   output logic                         M_TLAST,
   output logic                         M_TVALID,
   input  logic                         M_TREADY,
   input  logic                         CLR_ERR,
   output logic                         ERR_LAST,
   output logic                         ERR_RESP,
   output logic [15:0]                  BURST_CNT
);

   localparam int LANE_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [LANE_W-1:0] LANE_MAX = LANE_W'(NUM_CH - 1);
   localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BURST_LEN - 1);

   // A burst must hold a whole number of output words.
   generate
      if (BURST_LEN % NUM_CH != 0) begin : g_bad_burst_len
         $error("BURST_LEN must be a multiple of NUM_CH");
      end
   endgenerate

   logic [LANE_W-1:0]            lane_idx;
   logic [BEAT_W-1:0]            beat_idx;
   logic [DATA_WIDTH-1:0]        asm_lane [NUM_CH];
   logic [NUM_CH*DATA_WIDTH-1:0] out_dat;
   logic [NUM_CH-1:0]            out_keep;
   logic                         out_last;
   logic                         out_vld;
   logic                         err_last_q;
   logic                         err_resp_q;
   logic [15:0]                  burst_cnt_q;

   logic                         beat_at_end;
   logic                         closing;
   logic                         close_last;
   logic                         beat_rdy;
   logic                         beat_acc;
   logic                         last_err;
   logic                         resp_err;
   logic [NUM_CH*DATA_WIDTH-1:0] nxt_dat;
   logic [NUM_CH-1:0]            nxt_keep;

   // Close detection and beat acceptance; the M_TREADY -> S_RREADY path is intentionally combinational.
   always_comb begin
      beat_at_end = (beat_idx == BEAT_MAX);
      closing     = (lane_idx == LANE_MAX) || S_RLAST || beat_at_end;
      close_last  = S_RLAST || beat_at_end;
      beat_rdy    = M_AXI_ARESETN && !(out_vld && !M_TREADY && closing);
      beat_acc    = S_RVALID && beat_rdy;
      last_err    = beat_acc && (S_RLAST != beat_at_end);
      resp_err    = beat_acc && (rresp_t'(S_RRESP) != OKAY);
   end

   // Word to load on close: filled lanes from the assembly, current beat in its lane, the rest zero.
   always_comb begin
      nxt_dat  = '0;
      nxt_keep = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (LANE_W'(k) < lane_idx) begin
            nxt_dat[k*DATA_WIDTH +: DATA_WIDTH] = asm_lane[k];
            nxt_keep[k]                         = 1'b1;
         end else if (LANE_W'(k) == lane_idx) begin
            nxt_dat[k*DATA_WIDTH +: DATA_WIDTH] = S_RDATA;
            nxt_keep[k]                         = 1'b1;
         end
      end
   end

   // Lane and beat counters; a burst-closing word resyncs both to zero.
   always_ff @(posedge M_AXI_ACLK) begin
      if (!M_AXI_ARESETN) begin
         lane_idx <= '0;
         beat_idx <= '0;
      end else if (beat_acc) begin
         lane_idx <= closing ? '0 : lane_idx + 1'b1;
         beat_idx <= close_last ? '0 : beat_idx + 1'b1;
      end
   end

   // Assembly register collects the lanes of the group in progress.
   always_ff @(posedge M_AXI_ACLK) begin
      if (!M_AXI_ARESETN) begin
         for (int k = 0; k < NUM_CH; k++) begin
            asm_lane[k] <= '0;
         end
      end else if (beat_acc) begin
         asm_lane[lane_idx] <= S_RDATA;
      end
   end

   // Output register: reload on close (also in the handshake cycle), otherwise drop valid once taken.
   always_ff @(posedge M_AXI_ACLK) begin
      if (!M_AXI_ARESETN) begin
         out_vld  <= 1'b0;
         out_dat  <= '0;
         out_keep <= '0;
         out_last <= 1'b0;
      end else if (beat_acc && closing) begin
         out_vld  <= 1'b1;
         out_dat  <= nxt_dat;
         out_keep <= nxt_keep;
         out_last <= close_last;
      end else if (M_TREADY) begin
         out_vld  <= 1'b0;
      end
   end

   // Sticky error flags; a new error in the clear cycle keeps the flag set.
   always_ff @(posedge M_AXI_ACLK) begin
      if (!M_AXI_ARESETN) begin
         err_last_q <= 1'b0;
         err_resp_q <= 1'b0;
      end else begin
         err_last_q <= last_err | (err_last_q & ~CLR_ERR);
         err_resp_q <= resp_err | (err_resp_q & ~CLR_ERR);
      end
   end

   // Count bursts as their closing word is taken downstream.
   always_ff @(posedge M_AXI_ACLK) begin
      if (!M_AXI_ARESETN) begin
         burst_cnt_q <= '0;
      end else if (out_vld && M_TREADY && out_last) begin
         burst_cnt_q <= burst_cnt_q + 16'd1;
      end
   end

   assign S_RREADY  = beat_rdy;
   assign M_TDATA   = out_dat;
   assign M_TKEEP   = out_keep;
   assign M_TLAST   = out_last;
   assign M_TVALID  = out_vld;
   assign ERR_LAST  = err_last_q;
   assign ERR_RESP  = err_resp_q;
   assign BURST_CNT = burst_cnt_q;

endmodule

// File: tb/tb_tiadc_sample_deinterleaver.sv
// Bench for tiadc_sample_deinterleaver: directed scenarios plus randomized bursts against a queue model.
// Latency: model expects each word valid one edge after its closing beat.
// Backpressure: M_TREADY driven constant, scripted-stall or random.
module tb_tiadc_sample_deinterleaver;

   localparam int DW = 16;
   localparam int NC = 4;
   localparam int BL = 256;

   logic            clk;
   logic            arstn;
   logic [DW-1:0]   rdata;
   logic [1:0]      rresp;
   logic            rlast;
   logic            rvalid;
   logic            rready;
   logic [NC*DW-1:0] tdata;
   logic [NC-1:0]   tkeep;
   logic            tlast;
   logic            tvalid;
   logic            tready;
   logic            clr_err;
   logic            err_last;
   logic            err_resp;
   logic [15:0]     burst_cnt;

   tiadc_sample_deinterleaver #(
      .DATA_WIDTH (DW),
      .NUM_CH     (NC),
      .BURST_LEN  (BL)
   ) dut (
      .M_AXI_ACLK    (clk),
      .M_AXI_ARESETN (arstn),
      .S_RDATA       (rdata),
      .S_RRESP       (rresp),
      .S_RLAST       (rlast),
      .S_RVALID      (rvalid),
      .S_RREADY      (rready),
      .M_TDATA       (tdata),
      .M_TKEEP       (tkeep),
      .M_TLAST       (tlast),
      .M_TVALID      (tvalid),
      .M_TREADY      (tready),
      .CLR_ERR       (clr_err),
      .ERR_LAST      (err_last),
      .ERR_RESP      (err_resp),
      .BURST_CNT     (burst_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [NC*DW-1:0] data;
      logic [NC-1:0]    keep;
      logic             last;
   } word_t;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model state: beats of the open group, position in burst, expected words.
   logic [DW-1:0] grp[$];
   int            pos;
   word_t         exp_q[$];
   word_t         out_log[$];
   bit            m_err_last, m_err_resp;
   logic [15:0]   m_cnt;
   bit            checking = 0;
   bit            set_l, set_r, m_close, at_end, stall_prev;
   logic [NC*DW-1:0] prev_data;
   logic [NC-1:0] prev_keep;
   logic          prev_last;
   word_t         w, dw;
   int            stall_cycles;

   int tready_mode = 0;
   int stall_left  = 0;
   bit stall_done  = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Compare DUT against the model every cycle, then advance the model with this cycle's handshakes.
   always @(negedge clk) begin
      if (checking) begin
         check("tvalid", tvalid, exp_q.size() != 0);
         if (exp_q.size() != 0) begin
            check("tdata", tdata, exp_q[0].data);
            check("tkeep", tkeep, exp_q[0].keep);
            check("tlast", tlast, exp_q[0].last);
         end
         check("err_last", err_last, m_err_last);
         check("err_resp", err_resp, m_err_resp);
         check("burst_cnt", burst_cnt, m_cnt);
         m_close = (grp.size() == NC - 1) || rlast || (pos == BL - 1);
         check("s_rready", rready, arstn && !(tvalid && !tready && m_close));
         if (stall_prev) begin
            check("hold_tdata", tdata, prev_data);
            check("hold_tkeep", tkeep, prev_keep);
            check("hold_tlast", tlast, prev_last);
         end
      end
      stall_prev = checking && arstn && tvalid && !tready;
      prev_data  = tdata;
      prev_keep  = tkeep;
      prev_last  = tlast;
      if (arstn && rvalid && !rready) stall_cycles++;

      if (!arstn) begin
         grp.delete();
         exp_q.delete();
         pos        = 0;
         m_err_last = 0;
         m_err_resp = 0;
         m_cnt      = '0;
         stall_prev = 0;
         checking   = 1;
      end else if (checking) begin
         if (tvalid && tready && exp_q.size() != 0) begin
            w = exp_q.pop_front();
            dw.data = tdata;
            dw.keep = tkeep;
            dw.last = tlast;
            out_log.push_back(dw);
            if (w.last) m_cnt = m_cnt + 16'd1;
         end
         set_l = 0;
         set_r = 0;
         if (rvalid && rready) begin
            at_end = (pos == BL - 1);
            if (rresp != 2'b00) set_r = 1;
            if (rlast != at_end) set_l = 1;
            grp.push_back(rdata);
            if (grp.size() == NC || rlast || at_end) begin
               w.data = '0;
               for (int k = 0; k < grp.size(); k++) w.data[k*DW +: DW] = grp[k];
               w.keep = NC'((1 << grp.size()) - 1);
               w.last = rlast || at_end;
               exp_q.push_back(w);
               grp.delete();
            end
            pos = (rlast || at_end) ? 0 : pos + 1;
         end
         m_err_last = set_l | (m_err_last & !clr_err);
         m_err_resp = set_r | (m_err_resp & !clr_err);
      end
   end

   // Downstream ready: held high, random, or a single 5-cycle stall once word 3 is presented.
   always @(posedge clk) begin
      #1;
      case (tready_mode)
         0: tready = 1'b1;
         1: tready = ($urandom_range(3) != 0);
         default: begin
            if (stall_left > 0) begin
               tready = 1'b0;
               stall_left--;
            end else if (!stall_done && tvalid && out_log.size() == 3) begin
               tready     = 1'b0;
               stall_left = 4;
               stall_done = 1;
            end else begin
               tready = 1'b1;
            end
         end
      endcase
   end

   task automatic drive_beat(input logic [DW-1:0] d, input logic [1:0] resp, input logic last, input logic clr);
      bit acc;
      int guard = 0;
      rvalid  = 1'b1;
      rdata   = d;
      rresp   = resp;
      rlast   = last;
      clr_err = clr;
      do begin
         @(negedge clk);
         acc = rready;
         @(posedge clk);
         #1;
         guard++;
      end while (!acc && guard < 1000);
      if (!acc) check("beat_accept_timeout", 0, 1);
      rvalid  = 1'b0;
      rlast   = 1'b0;
      rresp   = 2'b00;
      clr_err = 1'b0;
   endtask

   task automatic send_burst(input int n, input int last_at, input int gap_pct, input bit rand_resp,
                             input int err_beat, input logic [1:0] err_code, input int clr_beat);
      logic [1:0] r;
      for (int i = 0; i < n; i++) begin
         if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            @(posedge clk);
            #1;
         end
         r = 2'b00;
         if (rand_resp && $urandom_range(31) == 0) r = 2'($urandom_range(3, 1));
         if (i == err_beat) r = err_code;
         drive_beat(16'hBEEF - 16'(i), r, i == last_at, i == clr_beat);
      end
   endtask

   task automatic drain();
      int guard = 0;
      while ((exp_q.size() != 0 || tvalid) && guard < 300) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (guard >= 300) check("drain_timeout", 0, 1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic clear_errors();
      clr_err = 1'b1;
      @(posedge clk);
      #1;
      clr_err = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      arstn   = 1'b0;
      rdata   = '0;
      rresp   = 2'b00;
      rlast   = 1'b0;
      rvalid  = 1'b0;
      clr_err = 1'b0;
      tready  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tvalid", tvalid, 0);
      check("rst_tdata", tdata, 0);
      check("rst_tkeep", tkeep, 0);
      check("rst_err_last", err_last, 0);
      check("rst_burst_cnt", burst_cnt, 0);
      check("rst_rready", rready, 0);
      arstn = 1'b1;
      @(posedge clk);
      #1;

      // Nominal burst.
      out_log.delete();
      send_burst(BL, BL - 1, 0, 0, -1, 2'b00, -1);
      drain();
      check("nom_words", out_log.size(), 64);
      check("nom_w0_data", out_log[0].data, 64'hBEEC_BEED_BEEE_BEEF);
      check("nom_w0_keep", out_log[0].keep, 4'hF);
      check("nom_w0_last", out_log[0].last, 0);
      check("nom_w63_last", out_log[63].last, 1);
      check("nom_burst_cnt", burst_cnt, 1);
      check("nom_err_last", err_last, 0);
      check("nom_err_resp", err_resp, 0);

      // Backpressure at word 3.
      out_log.delete();
      stall_cycles = 0;
      stall_done   = 0;
      tready_mode  = 2;
      send_burst(BL, BL - 1, 0, 0, -1, 2'b00, -1);
      drain();
      tready_mode = 0;
      check("bp_words", out_log.size(), 64);
      check("bp_stalled", stall_cycles >= 1 && stall_cycles <= 5, 1);
      check("bp_w3_data", out_log[3].data, 64'hBEE0_BEE1_BEE2_BEE3);
      check("bp_w4_data", out_log[4].data, 64'hBEDC_BEDD_BEDE_BEDF);

      // Early last on beat 5, then a normal burst.
      out_log.delete();
      send_burst(6, 5, 0, 0, -1, 2'b00, -1);
      drain();
      check("early_words", out_log.size(), 2);
      check("early_w1_data", out_log[1].data, 64'h0000_0000_BEEA_BEEB);
      check("early_w1_keep", out_log[1].keep, 4'h3);
      check("early_w1_last", out_log[1].last, 1);
      check("early_err_last", err_last, 1);
      send_burst(BL, BL - 1, 0, 0, -1, 2'b00, -1);
      drain();
      check("early_next_data", out_log[2].data, 64'hBEEC_BEED_BEEE_BEEF);
      check("early_next_keep", out_log[2].keep, 4'hF);

      // Missing last, then a normal burst.
      clear_errors();
      check("clr_err_last", err_last, 0);
      out_log.delete();
      send_burst(BL, -1, 0, 0, -1, 2'b00, -1);
      drain();
      check("miss_w63_last", out_log[63].last, 1);
      check("miss_err_last", err_last, 1);
      send_burst(BL, BL - 1, 0, 0, -1, 2'b00, -1);
      drain();
      check("miss_next_data", out_log[64].data, 64'hBEEC_BEED_BEEE_BEEF);
      check("miss_next_keep", out_log[64].keep, 4'hF);

      // Response error, clear, and clear colliding with DECERR.
      clear_errors();
      out_log.delete();
      send_burst(BL, BL - 1, 0, 0, 10, 2'b10, -1);
      drain();
      check("resp_err_resp", err_resp, 1);
      check("resp_err_last", err_last, 0);
      check("resp_w2_data", out_log[2].data, 64'hBEE4_BEE5_BEE6_BEE7);
      clear_errors();
      check("resp_cleared", err_resp, 0);
      send_burst(BL, BL - 1, 0, 0, 0, 2'b11, 0);
      drain();
      check("resp_clr_collide", err_resp, 1);

      // Reset in the middle of a burst.
      tready_mode = 1;
      send_burst(100, -1, 0, 0, -1, 2'b00, -1);
      rvalid = 1'b1;
      rdata  = 16'h1234;
      arstn  = 1'b0;
      @(negedge clk);
      check("midrst_rready", rready, 0);
      @(posedge clk);
      #1;
      check("midrst_tvalid", tvalid, 0);
      check("midrst_burst_cnt", burst_cnt, 0);
      rvalid = 1'b0;
      arstn  = 1'b1;
      tready_mode = 0;
      out_log.delete();
      @(posedge clk);
      #1;
      send_burst(BL, BL - 1, 0, 0, -1, 2'b00, -1);
      drain();
      check("midrst_words", out_log.size(), 64);
      check("midrst_w0_data", out_log[0].data, 64'hBEEC_BEED_BEEE_BEEF);
      check("midrst_burst_cnt2", burst_cnt, 1);

      // Randomized bursts: gaps, random ready, occasional early last and bad responses.
      tready_mode = 1;
      for (int b = 0; b < 8; b++) begin
         int la;
         la = ($urandom_range(3) == 0) ? int'($urandom_range(BL - 2)) : BL - 1;
         send_burst(BL, la, 20, 1, -1, 2'b00, int'($urandom_range(BL * 2)));
         if (la != BL - 1) begin
            for (int i = la + 1; i < BL; i++) begin
               drive_beat(16'($urandom), 2'b00, 1'b0, 1'b0);
            end
         end
      end
      tready_mode = 0;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tiadc_sample_deinterleaver.md
# tiadc_sample_deinterleaver

Downstream consumer of the AXI full read master's R channel in the TIADC capture path. Accepts 16-bit sample beats and regroups every NUM_CH consecutive beats into one parallel word, one lane per interleaved ADC channel. Presents each word on a valid/ready stream to the calibration datapath. Checks burst framing (RLAST position) and response codes, and raises sticky error flags.

## Interface
Parameters:
- DATA_WIDTH, 16, sample/beat width; equals the read master's data width.
- NUM_CH, 4, interleaved channels per output word; power of two, 2..16.
- BURST_LEN, 256, beats per AXI burst; multiple of NUM_CH, ≤ 256.

Ports (one clock; reset is synchronous and active-low):
- M_AXI_ACLK  in  1  system clock; all logic on rising edge.
- M_AXI_ARESETN  in  1  synchronous active-low reset.
- S_RDATA  in  DATA_WIDTH  beat data from read master.
- S_RRESP  in  2  beat response (OKAY/EXOKAY/SLVERR/DECERR).
- S_RLAST  in  1  last beat of burst.
- S_RVALID  in  1  beat valid.
- S_RREADY  out  1  beat accept; drives the read master's RREADY.
- M_TDATA  out  NUM_CH*DATA_WIDTH  grouped word; lane k at [k*DATA_WIDTH +: DATA_WIDTH].
- M_TKEEP  out  NUM_CH  per-lane valid mask.
- M_TLAST  out  1  word closes a burst.
- M_TVALID  out  1  output word valid.
- M_TREADY  in  1  downstream accept.
- CLR_ERR  in  1  single-cycle pulse; clears sticky errors.
- ERR_LAST  out  1  sticky: RLAST misplaced or missing.
- ERR_RESP  out  1  sticky: a beat carried RRESP ≠ OKAY.
- BURST_CNT  out  16  count of bursts delivered (words accepted with M_TLAST=1), wraps at 2^16.

## Operation
- A beat is accepted when S_RVALID && S_RREADY.
- A lane index (0..NUM_CH-1) and a beat index (0..BURST_LEN-1) increment per accepted beat.
- Each accepted beat is written into assembly lane[lane index]. The first beat of a group goes to lane 0.
- A group closes on one of three events:
  - lane index = NUM_CH-1;
  - S_RLAST on the accepted beat;
  - beat index = BURST_LEN-1.
- On close, the assembly moves to the output register:
  - M_TKEEP sets bits 0..lane index.
  - Unfilled lanes are zero.
  - M_TLAST = (S_RLAST || beat index = BURST_LEN-1).
  - Lane index clears. Beat index clears if M_TLAST, otherwise increments.
- Framing checks:
  - S_RLAST with beat index ≠ BURST_LEN-1 (early last): set ERR_LAST. The partial group is emitted with M_TLAST=1 and counters resync to 0.
  - Beat index = BURST_LEN-1 without S_RLAST (missing last): set ERR_LAST, M_TLAST=1, counters wrap to 0.
- Response check: S_RRESP ≠ OKAY on any accepted beat sets ERR_RESP. Data still passes.
- CLR_ERR clears both flags. If CLR_ERR coincides with a new error event, the error wins and the flag stays 1.
- BURST_CNT increments on M_TVALID && M_TREADY && M_TLAST.

## Timing
- Reset (ARESETN low at an edge): on the next edge M_TVALID, M_TDATA, M_TKEEP, M_TLAST, ERR_LAST, ERR_RESP and BURST_CNT are 0, and both counters are 0.
- S_RREADY is 0 while ARESETN is low.
- Reset mid-burst drops the assembly and the output word without emitting them.
- Latency: M_TVALID rises on the edge after the closing beat is accepted.
- Backpressure: S_RREADY = ARESETN && !(M_TVALID && !M_TREADY && closing), where closing is the close condition evaluated on the current S_RVALID beat.
  - Non-closing beats are always accepted.
  - This path from M_TREADY to S_RREADY is combinational by design.
- Throughput: one beat per cycle and one word per NUM_CH cycles, with no bubble when M_TREADY is held high.
- Simultaneous events: output handshake and a new close in the same cycle reload the output register with no gap.
- AXI-stream rule: M_TDATA, M_TKEEP and M_TLAST stay stable while M_TVALID && !M_TREADY.

## Structure
- Shared package tiadc_pkg holds:
  - typedef enum logic [1:0] rresp_t {OKAY, EXOKAY, SLVERR, DECERR};
  - default DATA_WIDTH and BURST_LEN constants, shared with the read master.
- Single module with no sub-module. Counters, assembly register and output register are inline.
- Elaboration-time assertion: BURST_LEN % NUM_CH == 0.

## Test plan
- Nominal burst: memory pattern 16'hBEEF−i, RVALID=1, RLAST at beat 255, M_TREADY=1.
  - Expect 64 words with word 0 = {16'hBEEC,16'hBEED,16'hBEEE,16'hBEEF} and M_TKEEP=4'hF.
  - Word 63 has M_TLAST=1. BURST_CNT=1. No errors.
- Backpressure: M_TREADY low for 5 cycles at word 3.
  - S_RREADY drops only on the closing beat of word 4.
  - Words 3 and 4 are output intact. No data lost or duplicated.
- Early last: RLAST on beat 5.
  - Expect word 1 = {0,0,16'hBEEA,16'hBEEB}, M_TKEEP=4'h3, M_TLAST=1, ERR_LAST=1.
  - The next burst starts at lane 0.
- Missing last: no RLAST at beat 255.
  - Word 63 has M_TLAST=1 and ERR_LAST=1. Beat 256 lands in lane 0.
- Response error and clear:
  - Beat 10 carries SLVERR: ERR_RESP=1 and data unchanged.
  - CLR_ERR pulse clears it. CLR_ERR coinciding with a DECERR beat leaves ERR_RESP=1.
- Reset mid-burst: ARESETN low at beat 100.
  - Next edge: M_TVALID=0, BURST_CNT=0.
  - After release, a fresh burst is regrouped from lane 0.
